// File: rtl/led7seg_disp_arbiter_pkg.sv
// Shared constants and state encoding for the
// 7-segment display ownership arbiter.
package led7seg_disp_arbiter_pkg;

  localparam int DIG_NUM = 8;
  localparam int SEG_NUM = 8;
  localparam int DISP_DAT_WIDTH = DIG_NUM * SEG_NUM;

  localparam logic [DISP_DAT_WIDTH-1:0] DISP_BLANK = '1;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/led7seg_disp_arbiter_prio_enc.sv
// Highest-index-set encoder: one-hot of the top set bit
// plus an any-valid flag.
module prio_enc #(
  parameter int N = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] oh_o,
  output logic         any_o
);

  always_comb begin
    oh_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        oh_o    = '0;
        oh_o[i] = 1'b1;
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/led7seg_disp_arbiter.sv
// Priority arbiter that hands a single 8-digit LED frame
// to one requester at a time, with dwell-gated preemption.
module led7seg_disp_arbiter
  import led7seg_disp_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DAT_WIDTH   = DISP_DAT_WIDTH,
  parameter int DWELL_CYC   = 125000000,
  parameter int REFRESH_CYC = 125000000,
  parameter logic [DAT_WIDTH-1:0] BLANK =
    DAT_WIDTH'(DISP_BLANK)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*DAT_WIDTH-1:0] req_dat,
  output logic [NUM_REQ-1:0]           grant,
  output logic [DAT_WIDTH-1:0]         dat,
  output logic                         vld
);

  localparam int DW = (DWELL_CYC > 0) ?
    $clog2(DWELL_CYC + 1) : 1;
  localparam int RW = (REFRESH_CYC > 0) ?
    $clog2(REFRESH_CYC + 1) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC);
  localparam logic [RW-1:0] REFR_LAST = RW'(REFRESH_CYC - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d, sel;
  logic                 vld_q, vld_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [RW-1:0]        refr_q, refr_d;
  logic [NUM_REQ-1:0]   hi_oh;
  logic                 hi_any;
  logic                 own_held;

  prio_enc #(.N(NUM_REQ)) u_prio_enc (
    .vec_i (req_vld),
    .oh_o  (hi_oh),
    .any_o (hi_any)
  );

  assign own_held = |(req_vld & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (hi_any) begin
          state_d = OWN;
          grant_d = hi_oh;
        end
      end
      OWN: begin
        // hi_oh differs from the held owner only if a higher index waits
        if (!own_held) begin
          grant_d = hi_oh;
          state_d = hi_any ? OWN : IDLE;
        end else if (hi_oh != grant_q &&
                     dwell_q == DWELL_MAX) begin
          grant_d = hi_oh;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) begin
        sel = sel | req_dat[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  always_comb begin
    dat_d   = (state_d == OWN) ? sel : BLANK;
    vld_d   = (grant_d != grant_q) ||
              (dat_d != dat_q) ||
              (refr_q == REFR_LAST);
    refr_d  = vld_d ? '0 : refr_q + RW'(1);
    dwell_d = dwell_q;
    if (grant_d != grant_q) begin
      dwell_d = '0;
    end else if (state_q == OWN &&
                 dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      dat_q   <= BLANK;
      vld_q   <= 1'b0;
      dwell_q <= '0;
      refr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      dwell_q <= dwell_d;
      refr_q  <= refr_d;
    end
  end

  assign grant = grant_q;
  assign dat   = dat_q;
  assign vld   = vld_q;

endmodule

// File: tb/tb_led7seg_disp_arbiter.sv
// Directed bench for the LED frame arbiter with
// NUM_REQ=3, DWELL_CYC=8, REFRESH_CYC=20.
module tb_led7seg_disp_arbiter;

  localparam int NR = 3;
  localparam int DWD = 64;
  localparam logic [DWD-1:0] BLK = '1;
  localparam logic [DWD-1:0] D0 = 64'h1111111111111111;
  localparam logic [DWD-1:0] D1 = 64'h2222222222222222;
  localparam logic [DWD-1:0] D2 = 64'h3333333333333333;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_vld = '0;
  logic [NR*DWD-1:0] req_dat = '0;
  logic [NR-1:0]     grant;
  logic [DWD-1:0]    dat;
  logic              vld;

  int checks = 0;
  int failures = 0;

  always #4 clk = ~clk;

  led7seg_disp_arbiter #(
    .NUM_REQ     (NR),
    .DAT_WIDTH   (DWD),
    .DWELL_CYC   (8),
    .REFRESH_CYC (20),
    .BLANK       (BLK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_dat (req_dat),
    .grant   (grant),
    .dat     (dat),
    .vld     (vld)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_vld = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int pulses;
    int first;
    bit held;
    rst = 1'b1;
    req_vld = '0;
    req_dat = '0;
    step();
    checks++;
    if (grant !== 3'b000 || dat !== BLK || vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: grant=%b dat=%h vld=%b want 000 %h 0",
               grant, dat, vld, BLK);
    end
    step();
    rst = 1'b0;
    pulses = 0;
    first = -1;
    held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (vld === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (grant !== 3'b000 || dat !== BLK) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL idle_hold: grant=%b dat=%h want 000 blank", grant, dat);
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL idle_refresh_count: got %0d want 2", pulses);
    end
    checks++;
    if (first !== 20) begin
      failures++;
      $display("FAIL idle_refresh_first: got %0d want 20", first);
    end
  endtask

  task automatic test_single;
    do_reset();
    req_dat[0 +: DWD] = D0;
    req_vld = 3'b001;
    step();
    checks++;
    if (grant !== 3'b001 || dat !== D0 || vld !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b dat=%h vld=%b want 001 %h 1",
               grant, dat, vld, D0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (grant !== 3'b001 || vld !== 1'b0) begin
        failures++;
        $display("FAIL single_hold[%0d]: grant=%b vld=%b want 001 0",
                 i, grant, vld);
      end
    end
  endtask

  task automatic test_preempt;
    do_reset();
    req_dat[0 +: DWD] = D0;
    req_dat[2*DWD +: DWD] = D2;
    req_vld = 3'b001;
    step();
    step();
    step();
    req_vld = 3'b101;
    for (int k = 3; k <= 8; k++) begin
      step();
      checks++;
      if (grant !== 3'b001 || vld !== 1'b0) begin
        failures++;
        $display("FAIL preempt_wait[%0d]: grant=%b vld=%b want 001 0",
                 k, grant, vld);
      end
    end
    step();
    checks++;
    if (grant !== 3'b100 || dat !== D2 || vld !== 1'b1) begin
      failures++;
      $display("FAIL preempt_switch: grant=%b dat=%h vld=%b want 100 %h 1",
               grant, dat, vld, D2);
    end
  endtask

  task automatic test_release;
    do_reset();
    req_dat[DWD +: DWD] = D1;
    req_dat[2*DWD +: DWD] = D2;
    req_vld = 3'b100;
    step();
    req_vld = 3'b110;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (grant !== 3'b100 || vld !== 1'b0) begin
        failures++;
        $display("FAIL lower_no_preempt[%0d]: grant=%b vld=%b want 100 0",
                 i, grant, vld);
      end
    end
    req_vld = 3'b010;
    step();
    checks++;
    if (grant !== 3'b010 || dat !== D1 || vld !== 1'b1) begin
      failures++;
      $display("FAIL release_handoff: grant=%b dat=%h vld=%b want 010 %h 1",
               grant, dat, vld, D1);
    end
    req_vld = 3'b000;
    step();
    checks++;
    if (grant !== 3'b000 || dat !== BLK || vld !== 1'b1) begin
      failures++;
      $display("FAIL release_idle: grant=%b dat=%h vld=%b want 000 blank 1",
               grant, dat, vld);
    end
    step();
    checks++;
    if (vld !== 1'b0) begin
      failures++;
      $display("FAIL release_quiet: vld=%b want 0", vld);
    end
  endtask

  task automatic test_drop_and_rise;
    do_reset();
    req_dat[0 +: DWD] = D0;
    req_dat[2*DWD +: DWD] = D2;
    req_vld = 3'b001;
    step();
    step();
    req_vld = 3'b110;
    step();
    checks++;
    if (grant !== 3'b100 || dat !== D2 || vld !== 1'b1) begin
      failures++;
      $display("FAIL drop_and_rise: grant=%b dat=%h vld=%b want 100 %h 1",
               grant, dat, vld, D2);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    logic [DWD-1:0] last;
    do_reset();
    req_dat[DWD +: DWD] = {8{8'hA0}};
    req_vld = 3'b010;
    step();
    step();
    checks++;
    if (vld !== 1'b0 || dat !== {8{8'hA0}}) begin
      failures++;
      $display("FAIL track_settle: vld=%b dat=%h want 0 a0..", vld, dat);
    end
    last = {8{8'hA0}};
    for (int i = 1; i <= 4; i++) begin
      b = 8'hA0 + 8'(i);
      req_dat[DWD +: DWD] = {8{b}};
      last = {8{b}};
      step();
      checks++;
      if (vld !== 1'b1 || dat !== last) begin
        failures++;
        $display("FAIL track_pulse[%0d]: vld=%b dat=%h want 1 %h",
                 i, vld, dat, last);
      end
    end
    req_dat[0 +: DWD] = 64'h0123456789ABCDEF;
    req_dat[2*DWD +: DWD] = 64'hFEDCBA9876543210;
    for (int i = 1; i <= 19; i++) begin
      step();
      checks++;
      if (vld !== 1'b0 || dat !== last) begin
        failures++;
        $display("FAIL track_quiet[%0d]: vld=%b dat=%h want 0 %h",
                 i, vld, dat, last);
      end
    end
    step();
    checks++;
    if (vld !== 1'b1 || dat !== last) begin
      failures++;
      $display("FAIL track_refresh: vld=%b dat=%h want 1 %h",
               vld, dat, last);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_dat[2*DWD +: DWD] = D2;
    req_vld = 3'b111;
    step();
    step();
    step();
    checks++;
    if (grant !== 3'b100) begin
      failures++;
      $display("FAIL mid_own: grant=%b want 100", grant);
    end
    rst = 1'b1;
    step();
    checks++;
    if (grant !== 3'b000 || dat !== BLK || vld !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: grant=%b dat=%h vld=%b want 000 blank 0",
               grant, dat, vld);
    end
    rst = 1'b0;
    step();
    checks++;
    if (grant !== 3'b100 || dat !== D2 || vld !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: grant=%b dat=%h vld=%b want 100 %h 1",
               grant, dat, vld, D2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_release();
    test_drop_and_rise();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led7seg_disp_arbiter.md
LED7SEG_DISP_ARBITER -- requirements
Module: led7seg_disp_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed first as follows.
REQ-002 clk  input  1  system clock, 125 MHz.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 Parameters SHALL be:
- NUM_REQ, default 3: number of requesters.
- DAT_WIDTH, default 64: frame width, 8 digits x 8 segments.
- DWELL_CYC, default 125000000: minimum ownership cycles before preemption.
- REFRESH_CYC, default 125000000: maximum cycles between frame pulses.
- BLANK, default all ones: frame shown when no requester owns the display.
REQ-005 req_vld  input  NUM_REQ  per-requester level request; higher index means higher priority.
REQ-006 req_dat  input  NUM_REQ*DAT_WIDTH  concatenated frames; requester i occupies bits [i*DAT_WIDTH +: DAT_WIDTH].
REQ-007 grant  output  NUM_REQ  one-hot current owner; all zeros when idle.
REQ-008 dat  output  DAT_WIDTH  registered frame to the 74HC595 display controller.
REQ-009 vld  output  1  one-cycle frame-load pulse to the display controller.

Function
REQ-010 The state machine SHALL have two states: IDLE (no owner) and OWN (exactly one grant bit set).
REQ-011 From IDLE with any req_vld set, the block SHALL enter OWN and grant the highest-index requester on the next edge.
REQ-012 In OWN, if req_vld[owner] drops, the block SHALL re-arbitrate on the next edge:
- grant the highest pending requester; or
- enter IDLE if none is pending.
No dwell applies in this case.
REQ-013 In OWN, a higher-index request SHALL preempt the owner only when the dwell counter equals DWELL_CYC; until then the owner keeps the grant.
REQ-014 A lower-index request SHALL never preempt; a lower-index requester is served only after the owner releases.
REQ-015 The dwell counter SHALL clear to 0 on every grant change and increment each cycle in OWN, saturating at DWELL_CYC.
REQ-016 If the owner drops and a higher-index request rises in the same cycle, the block SHALL grant the highest pending requester without any dwell.
REQ-017 grant, dat and vld SHALL all update on the same edge from the current-cycle inputs.
- Latency from a req_vld or req_dat change to the output is exactly 1 cycle.
REQ-018 dat SHALL equal the owner's req_dat sampled at the previous edge while in OWN, and BLANK while in IDLE.
REQ-019 vld SHALL pulse high for exactly one cycle when any of the following occurs at that edge:
- (a) grant changes, including entry to IDLE;
- (b) the new dat differs from the previous dat;
- (c) the refresh counter reaches REFRESH_CYC-1.
REQ-020 The refresh counter SHALL clear on every vld pulse and otherwise increment; it wraps only through condition (c).
REQ-021 vld SHALL never be high on two consecutive cycles unless dat changed on both edges.
REQ-022 Counter widths SHALL be ceil(log2(limit+1)) bits, with no overflow at the parameter maxima.
REQ-023 req_vld and req_dat of non-owners SHALL have no effect on dat.

Reset
REQ-024 While rst is high at an edge, the block SHALL set:
- state = IDLE, grant = 0, dat = BLANK, vld = 0;
- dwell counter = 0, refresh counter = 0.
REQ-025 Reset asserted mid-ownership SHALL drop the grant at that edge with no vld pulse.
REQ-026 After reset is released, the block SHALL arbitrate on the first edge, following REQ-011.

Structure
REQ-027 A shared package SHALL hold:
- the DAT_WIDTH and DIG_NUM/SEG_NUM constants;
- the BLANK frame constant;
- the state encoding (IDLE, OWN).
REQ-028 One sub-module, prio_enc, SHALL perform the highest-index-set encoding of a NUM_REQ vector into one-hot form plus an any-valid flag.
REQ-029 The block SHALL contain no display-protocol logic; dat and vld connect directly to the dat and vld ports of the existing 74HC595 controller wrapper.

Verification
All scenarios run with NUM_REQ=3, DWELL_CYC=8, REFRESH_CYC=20, BLANK=all ones.
REQ-030 Reset, no requests: dat=BLANK and grant=0 held; vld pulses once every 20 cycles.
REQ-031 req_vld=001 with req_dat[0]=0x1111..., held 5 cycles: grant=001 and dat=0x1111... one cycle later, with a single vld pulse at that edge.
REQ-032 Owner 0 active 3 cycles, then req_vld=101: grant stays 001 until the dwell counter reaches 8, then switches to 100 with a vld pulse.
REQ-033 Owner 2, req_vld changes 110->010 with req_dat[1]=0x2222...: grant=010 and dat=0x2222... on the next edge with no dwell; then req_vld=000 gives grant=0, dat=BLANK and a vld pulse.
REQ-034 Owner 1, req_dat[1] changes every cycle for 4 cycles: 4 consecutive vld pulses; dat tracks with 1-cycle lag; the refresh counter clears each time.
REQ-035 rst asserted mid-OWN with req_vld=111: grant=0, dat=BLANK and vld=0 at that edge; grant=100 on the first edge after release.
